// File: rtl/bw_bridge_pkg.sv
// Shared types and constants for the 128-to-32 Wishbone width bridge.
package bw_bridge_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 32;
    localparam int SEL_W  = LANE_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } bw_state_e;

    // Beat timeout counter width; it only ever counts up to cycles-1.
    function automatic int to_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/bw_lane_pick.sv
// Lowest-set-bit encoder: chooses the next 32-bit lane still pending.
module bw_lane_pick
    import bw_bridge_pkg::*;
(
    input  logic [LANES-1:0] pend,
    output logic [1:0]       lane,
    output logic             any
);

    // Priority encode, lane 0 first
    always_comb begin
        lane = 2'd0;
        casez (pend)
            4'b???1: lane = 2'd0;
            4'b??10: lane = 2'd1;
            4'b?100: lane = 2'd2;
            4'b1000: lane = 2'd3;
            default: lane = 2'd0;
        endcase
        any = |pend;
    end

endmodule

// File: rtl/bw_wb128to32_bridge.sv
// Splits 128-bit MPU Wishbone accesses into 32-bit peripheral beats, one per active sel nibble.
// Optional beat timeout: define BW_BRIDGE_TIMEOUT_EN.
module bw_wb128to32_bridge
    import bw_bridge_pkg::*;
#(
    parameter logic [31:0] ADR_MATCH = 32'hFF90_0000,
    parameter logic [31:0] ADR_MASK  = 32'hFFF0_0000,
    parameter int          TO_CYCLES = 256
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         s_cyc_i,
    input  logic         s_stb_i,
    input  logic         s_we_i,
    input  logic [15:0]  s_sel_i,
    input  logic [31:0]  s_adr_i,
    input  logic [127:0] s_dat_i,
    output logic         s_ack_o,
    output logic         s_err_o,
    output logic [127:0] s_dat_o,
    output logic         m_cyc_o,
    output logic         m_stb_o,
    output logic         m_we_o,
    output logic [3:0]   m_sel_o,
    output logic [31:0]  m_adr_o,
    output logic [31:0]  m_dat_o,
    input  logic         m_ack_i,
    input  logic         m_err_i,
    input  logic [31:0]  m_dat_i
);

    bw_state_e          state_r, state_nxt_s;
    logic [LANES-1:0]   pend_r, pend_nxt_s;
    logic [1:0]         lane_r, lane_nxt_s;
    logic               any_nxt_s;
    logic [31:4]        adr_r, adr_nxt_s;
    logic               we_r, we_nxt_s;
    logic [15:0]        sel_r, sel_nxt_s;
    logic [127:0]       wdata_r, wdata_nxt_s;
    logic [127:0]       rdata_r, rdata_nxt_s;
    logic               err_r, err_nxt_s;
    logic               hit_s, beat_live_s, beat_err_s, beat_ack_s, to_hit_s;

    logic               s_ack_nxt_s, s_err_nxt_s;
    logic [127:0]       s_dat_nxt_s;
    logic               m_cyc_nxt_s, m_stb_nxt_s, m_we_nxt_s;
    logic [3:0]         m_sel_nxt_s;
    logic [31:0]        m_adr_nxt_s, m_dat_nxt_s;

    assign hit_s       = s_cyc_i & s_stb_i & ((s_adr_i & ADR_MASK) == (ADR_MATCH & ADR_MASK));
    assign beat_live_s = (state_r == BEAT) & m_stb_o;
    // Error (or timeout) wins over a simultaneous ack
    assign beat_err_s  = beat_live_s & (m_err_i | to_hit_s);
    assign beat_ack_s  = beat_live_s & m_ack_i & ~beat_err_s;

`ifdef BW_BRIDGE_TIMEOUT_EN
    localparam int              TO_W    = to_cnt_width(TO_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);
    logic [TO_W-1:0]            to_cnt_r;

    // Beat timeout counter, restarted on every entry to BEAT
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (state_r != BEAT) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (to_cnt_r != TO_LAST) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    assign to_hit_s = (state_r == BEAT) & (to_cnt_r == TO_LAST) & ~m_ack_i & ~m_err_i;
`else
    assign to_hit_s = 1'b0;
`endif

    bw_lane_pick u_lane_pick (
        .pend (pend_nxt_s),
        .lane (lane_nxt_s),
        .any  (any_nxt_s)
    );

    // Next-state and captured-transaction logic
    always_comb begin
        state_nxt_s = state_r;
        pend_nxt_s  = pend_r;
        adr_nxt_s   = adr_r;
        we_nxt_s    = we_r;
        sel_nxt_s   = sel_r;
        wdata_nxt_s = wdata_r;
        rdata_nxt_s = rdata_r;
        err_nxt_s   = err_r;
        case (state_r)
            IDLE: begin
                if (hit_s) begin
                    adr_nxt_s   = s_adr_i[31:4];
                    we_nxt_s    = s_we_i;
                    sel_nxt_s   = s_sel_i;
                    wdata_nxt_s = s_dat_i;
                    rdata_nxt_s = 128'd0;
                    err_nxt_s   = 1'b0;
                    for (int l = 0; l < LANES; l++) begin
                        pend_nxt_s[l] = |s_sel_i[SEL_W*l +: SEL_W];
                    end
                    state_nxt_s = (|s_sel_i) ? BEAT : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BEAT: begin
                if (!s_cyc_i) begin
                    pend_nxt_s  = {LANES{1'b0}};
                    state_nxt_s = IDLE;
                end else if (beat_err_s) begin
                    err_nxt_s   = 1'b1;
                    pend_nxt_s  = {LANES{1'b0}};
                    state_nxt_s = DONE;
                end else if (beat_ack_s) begin
                    if (!we_r) begin
                        rdata_nxt_s[LANE_W*int'(lane_r) +: LANE_W] = m_dat_i;
                    end else begin
                        rdata_nxt_s = rdata_r;
                    end
                    pend_nxt_s[lane_r] = 1'b0;
                    state_nxt_s = (pend_nxt_s == {LANES{1'b0}}) ? DONE : GAP;
                end else begin
                    state_nxt_s = BEAT;
                end
            end
            GAP: begin
                if (!s_cyc_i) begin
                    pend_nxt_s  = {LANES{1'b0}};
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BEAT;
                end
            end
            DONE: begin
                if (!s_stb_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                pend_nxt_s  = {LANES{1'b0}};
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        s_ack_nxt_s = 1'b0;
        s_err_nxt_s = 1'b0;
        s_dat_nxt_s = 128'd0;
        m_cyc_nxt_s = 1'b0;
        m_stb_nxt_s = 1'b0;
        m_we_nxt_s  = 1'b0;
        m_sel_nxt_s = 4'd0;
        m_adr_nxt_s = 32'd0;
        m_dat_nxt_s = 32'd0;
        case (state_nxt_s)
            BEAT: begin
                m_cyc_nxt_s = 1'b1;
                m_stb_nxt_s = any_nxt_s;
                m_we_nxt_s  = we_nxt_s;
                m_adr_nxt_s = {adr_nxt_s, lane_nxt_s, 2'b00};
                m_sel_nxt_s = sel_nxt_s[SEL_W*int'(lane_nxt_s) +: SEL_W];
                m_dat_nxt_s = wdata_nxt_s[LANE_W*int'(lane_nxt_s) +: LANE_W];
            end
            GAP: begin
                m_cyc_nxt_s = 1'b1;
                m_we_nxt_s  = we_nxt_s;
                m_adr_nxt_s = {adr_nxt_s, lane_nxt_s, 2'b00};
            end
            DONE: begin
                s_ack_nxt_s = ~err_nxt_s;
                s_err_nxt_s = err_nxt_s;
                if (!err_nxt_s && !we_nxt_s) begin
                    s_dat_nxt_s = rdata_nxt_s;
                end else begin
                    s_dat_nxt_s = 128'd0;
                end
            end
            default: begin
                s_ack_nxt_s = 1'b0;
            end
        endcase
    end

    // State and transaction registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            pend_r  <= {LANES{1'b0}};
            lane_r  <= 2'd0;
            adr_r   <= 28'd0;
            we_r    <= 1'b0;
            sel_r   <= 16'd0;
            wdata_r <= 128'd0;
            rdata_r <= 128'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pend_r  <= pend_nxt_s;
            lane_r  <= lane_nxt_s;
            adr_r   <= adr_nxt_s;
            we_r    <= we_nxt_s;
            sel_r   <= sel_nxt_s;
            wdata_r <= wdata_nxt_s;
            rdata_r <= rdata_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Output registers; zero whenever the bridge is not responding
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_ack_o <= 1'b0;
            s_err_o <= 1'b0;
            s_dat_o <= 128'd0;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            m_sel_o <= 4'd0;
            m_adr_o <= 32'd0;
            m_dat_o <= 32'd0;
        end else begin
            s_ack_o <= s_ack_nxt_s;
            s_err_o <= s_err_nxt_s;
            s_dat_o <= s_dat_nxt_s;
            m_cyc_o <= m_cyc_nxt_s;
            m_stb_o <= m_stb_nxt_s;
            m_we_o  <= m_we_nxt_s;
            m_sel_o <= m_sel_nxt_s;
            m_adr_o <= m_adr_nxt_s;
            m_dat_o <= m_dat_nxt_s;
        end
    end

endmodule

// File: tb/tb_bw_wb128to32_bridge.sv
// Directed self-checking bench for bw_wb128to32_bridge (default build, no timeout).
module tb_bw_wb128to32_bridge;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         s_cyc_i, s_stb_i, s_we_i;
    logic [15:0]  s_sel_i;
    logic [31:0]  s_adr_i;
    logic [127:0] s_dat_i;
    logic         s_ack_o, s_err_o;
    logic [127:0] s_dat_o;
    logic         m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]   m_sel_o;
    logic [31:0]  m_adr_o, m_dat_o;
    logic         m_ack_i, m_err_i;
    logic [31:0]  m_dat_i;

    logic         ack_mode, err_mode;
    logic [31:0]  rd_words [4];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] log_adr [$];
    logic [3:0]  log_sel [$];
    logic [31:0] log_dat [$];
    int cyc_cnt = 0, gap_cnt = 0, ack_rises = 0, sdat_nz = 0;
    logic ack_prev = 1'b0;

    always #5 clk_i = ~clk_i;

    // Zero-wait peripheral model
    assign m_ack_i = m_stb_o & ack_mode;
    assign m_err_i = m_stb_o & err_mode;
    assign m_dat_i = m_stb_o ? rd_words[m_adr_o[3:2]] : 32'd0;

    bw_wb128to32_bridge dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i),
        .s_sel_i(s_sel_i), .s_adr_i(s_adr_i), .s_dat_i(s_dat_i),
        .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_dat_o(s_dat_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
        .m_sel_o(m_sel_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
        .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_dat_i(m_dat_i)
    );

    // Bus monitor, sampled mid-cycle
    always @(negedge clk_i) begin
        if (m_stb_o && (m_ack_i || m_err_i)) begin
            log_adr.push_back(m_adr_o);
            log_sel.push_back(m_sel_o);
            log_dat.push_back(m_we_o ? m_dat_o : m_dat_i);
        end
        if (m_cyc_o) cyc_cnt++;
        if (m_cyc_o && !m_stb_o) gap_cnt++;
        if (s_ack_o && !ack_prev) ack_rises++;
        if (s_dat_o != 128'd0) sdat_nz++;
        ack_prev = s_ack_o;
    end

    task automatic chk_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_access(input logic we, input logic [15:0] sel, input logic [31:0] adr,
                             input logic [127:0] wd, output int lat, output logic ack,
                             output logic err, output logic [127:0] rd);
        bit done;
        done = 1'b0; lat = -1; ack = 1'b0; err = 1'b0; rd = 128'd0;
        @(negedge clk_i);
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we;
        s_sel_i = sel; s_adr_i = adr; s_dat_i = wd;
        for (int i = 1; i <= 64; i++) begin
            if (!done) begin
                @(posedge clk_i); #1;
                if (s_ack_o || s_err_o) begin
                    done = 1'b1; lat = i; ack = s_ack_o; err = s_err_o; rd = s_dat_o;
                end
            end
        end
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
        s_sel_i = 16'd0; s_adr_i = 32'd0; s_dat_i = 128'd0;
        repeat (2) @(posedge clk_i);
    endtask

    int           lat, b, c0, g0, a0;
    logic         ack, err;
    logic [127:0] rd;
    logic [31:0]  wexp [4];

    initial begin
        rst_i = 1'b1; s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
        s_sel_i = 16'd0; s_adr_i = 32'd0; s_dat_i = 128'd0;
        ack_mode = 1'b1; err_mode = 1'b0;
        rd_words[0] = 32'hA0A0_0000; rd_words[1] = 32'h1234_5678;
        rd_words[2] = 32'hC2C2_2222; rd_words[3] = 32'hD3D3_3333;
        wexp[0] = 32'hAAAA_AAAA; wexp[1] = 32'hBBBB_BBBB;
        wexp[2] = 32'hCCCC_CCCC; wexp[3] = 32'hDDDD_DDDD;
        repeat (3) @(posedge clk_i);
        #1;
        chk_val("rst_ack", s_ack_o, 1'b0);
        chk_val("rst_cyc", m_cyc_o, 1'b0);
        chk_val("rst_stb", m_stb_o, 1'b0);
        chk_val("rst_sdat", s_dat_o, 128'd0);
        @(negedge clk_i); rst_i = 1'b0;
        repeat (2) @(posedge clk_i);

        // Single-lane read in lane 1
        b = log_adr.size();
        do_access(1'b0, 16'h00F0, 32'hFF90_0010, 128'd0, lat, ack, err, rd);
        chk_val("rd1_ack", ack, 1'b1);
        chk_val("rd1_err", err, 1'b0);
        chk_val("rd1_lat", lat, 2);
        chk_val("rd1_dat", rd, 128'h0000_0000_0000_0000_1234_5678_0000_0000);
        chk_val("rd1_beats", log_adr.size() - b, 1);
        chk_val("rd1_adr", log_adr[b], 32'hFF90_0014);
        chk_val("rd1_sel", log_sel[b], 4'hF);

        // Full-width write, four beats with gaps
        b = log_adr.size(); g0 = gap_cnt; a0 = ack_rises;
        do_access(1'b1, 16'hFFFF, 32'hFF90_0100,
                  128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA, lat, ack, err, rd);
        chk_val("wr_ack", ack, 1'b1);
        chk_val("wr_lat", lat, 8);
        chk_val("wr_sdat", rd, 128'd0);
        chk_val("wr_beats", log_adr.size() - b, 4);
        chk_val("wr_gaps", gap_cnt - g0, 3);
        chk_val("wr_ackrise", ack_rises - a0, 1);
        for (int l = 0; l < 4; l++) begin
            chk_val($sformatf("wr_adr%0d", l), log_adr[b+l], 32'hFF90_0100 + 32'(4*l));
            chk_val($sformatf("wr_dat%0d", l), log_dat[b+l], wexp[l]);
        end

        // Partial nibbles in lanes 2 and 3
        b = log_adr.size();
        do_access(1'b0, 16'h3C00, 32'hFF9A_BCD0, 128'd0, lat, ack, err, rd);
        chk_val("rd23_lat", lat, 4);
        chk_val("rd23_dat", rd, 128'hD3D3_3333_C2C2_2222_0000_0000_0000_0000);
        chk_val("rd23_adr2", log_adr[b], 32'hFF9A_BCD8);
        chk_val("rd23_sel2", log_sel[b], 4'hC);
        chk_val("rd23_adr3", log_adr[b+1], 32'hFF9A_BCDC);
        chk_val("rd23_sel3", log_sel[b+1], 4'h3);

        // Empty sel: acked with no beats
        b = log_adr.size();
        do_access(1'b0, 16'h0000, 32'hFF90_0040, 128'd0, lat, ack, err, rd);
        chk_val("sel0_ack", ack, 1'b1);
        chk_val("sel0_lat", lat, 1);
        chk_val("sel0_beats", log_adr.size() - b, 0);

        // Error on first beat stops remaining lanes
        ack_mode = 1'b0; err_mode = 1'b1;
        b = log_adr.size(); a0 = ack_rises;
        do_access(1'b0, 16'h0F0F, 32'hFF90_0000, 128'd0, lat, ack, err, rd);
        chk_val("err_err", err, 1'b1);
        chk_val("err_ack", ack, 1'b0);
        chk_val("err_dat", rd, 128'd0);
        chk_val("err_beats", log_adr.size() - b, 1);
        chk_val("err_adr", log_adr[b], 32'hFF90_0000);
        chk_val("err_noack", ack_rises - a0, 0);
        ack_mode = 1'b1; err_mode = 1'b0;

        // Miss: nothing moves
        c0 = cyc_cnt; a0 = ack_rises; g0 = sdat_nz;
        @(negedge clk_i);
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_adr_i = 32'h0010_0000; s_sel_i = 16'hFFFF;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_adr_i = 32'd0; s_sel_i = 16'd0;
        chk_val("miss_cyc", cyc_cnt - c0, 0);
        chk_val("miss_ack", ack_rises - a0, 0);
        chk_val("miss_sdat", sdat_nz - g0, 0);

        // Abort: s_cyc dropped during a stalled beat
        ack_mode = 1'b0; a0 = ack_rises;
        @(negedge clk_i);
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_adr_i = 32'hFF90_0000; s_sel_i = 16'h000F;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_sel_i = 16'd0;
        repeat (3) @(posedge clk_i); #1;
        chk_val("abort_cyc", m_cyc_o, 1'b0);
        chk_val("abort_ack", ack_rises - a0, 0);

        // Asynchronous reset mid-beat of a four-lane read
        @(negedge clk_i);
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_adr_i = 32'hFF90_0000; s_sel_i = 16'hFFFF;
        repeat (3) @(posedge clk_i); #1;
        chk_val("mid_stb", m_stb_o, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        chk_val("arst_cyc", m_cyc_o, 1'b0);
        chk_val("arst_stb", m_stb_o, 1'b0);
        chk_val("arst_ack", s_ack_o, 1'b0);
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_sel_i = 16'd0; s_adr_i = 32'd0;
        @(negedge clk_i); @(negedge clk_i); rst_i = 1'b0;
        ack_mode = 1'b1;
        do_access(1'b0, 16'h000F, 32'hFF90_0020, 128'd0, lat, ack, err, rd);
        chk_val("post_ack", ack, 1'b1);
        chk_val("post_lat", lat, 2);
        chk_val("post_dat", rd, {96'd0, 32'hA0A0_0000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bw_wb128to32_bridge.md
# bw_wb128to32_bridge

Wishbone width bridge between the 128-bit registered MPU bus (cyc/stb/we/sel/adr/dat outputs of the CPU wrapper) and 32-bit peripherals such as UART, SPI and GPIO. It claims an address window and splits each 128-bit access into one 32-bit beat per active sel nibble, lowest lane first. It reassembles read data into the 128-bit lane positions and returns a single ack or err. Because the MPU ORs slave data and acks, every output toward the MPU is zero whenever the bridge is not responding.

## Interface
- ADR_MATCH, 32'hFF90_0000, window base compared under ADR_MASK
- ADR_MASK, 32'hFFF0_0000, bits of s_adr_i compared for selection
- TO_CYCLES, 256, beat timeout in clocks (used only with the timeout feature)
- clk_i  in  1  sole clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- s_cyc_i, s_stb_i, s_we_i  in  1  MPU-side cycle, strobe, write
- s_sel_i  in  16  byte lanes; nibble n maps to 32-bit lane n
- s_adr_i  in  32  byte address; bits [3:0] ignored
- s_dat_i  in  128  write data
- s_ack_o, s_err_o  out  1  termination to MPU
- s_dat_o  out  128  read data; zero except in ack cycles of reads
- m_cyc_o, m_stb_o, m_we_o  out  1  peripheral-side cycle, strobe, write
- m_sel_o  out  4  byte enables of the current beat
- m_adr_o  out  32  {adr[31:4], lane[1:0], 2'b00}
- m_dat_o  out  32  write word of the current lane
- m_ack_i, m_err_i  in  1  peripheral termination; sampled only while m_stb_o=1
- m_dat_i  in  32  peripheral read data

## Operation
- hit = s_cyc_i & s_stb_i & ((s_adr_i & ADR_MASK) == (ADR_MATCH & ADR_MASK)).
- States are IDLE, BEAT, GAP and DONE.
- IDLE: on hit, register adr, we and wdata. Set pend[3:0] = per-nibble OR of s_sel_i. Clear rdata and err.
  - pend==0: go to DONE, with no beats issued.
  - Otherwise: go to BEAT.
- BEAT drives m_cyc_o=m_stb_o=1 for lane L, the lowest set bit of pend.
  - m_sel_o = sel nibble L; m_dat_o = wdata word L.
- On m_ack_i in BEAT: write m_dat_i into rdata word L (reads only) and clear pend[L].
  - pend now 0: go to DONE.
  - Otherwise: go to GAP.
- On m_err_i in BEAT: set err, clear pend and go to DONE. Remaining lanes are not issued.
  - m_err_i takes priority if it arrives together with m_ack_i.
- GAP: m_stb_o=0 and m_cyc_o=1 for one clock, then BEAT with the next lane.
- DONE: m_cyc_o=0. Assert s_ack_o, or s_err_o if err, and hold it until s_stb_i=0, then go to IDLE.
  - On a read ack, s_dat_o = rdata with unaccessed words zero.
  - With err, s_dat_o is always 0.
- Abort: if s_cyc_i=0 in BEAT or GAP, drop m_cyc_o and m_stb_o next clock and go to IDLE with no ack.
- Non-hit accesses: all outputs stay 0.
- Reset (async, any state): state=IDLE, pend=0, and every output is 0 immediately.

## Timing
- Hit sampled at edge N: m_stb_o high from N+1.
- m_ack_i sampled at edge k: m_stb_o low from k+1.
  - Next beat strobes at k+2.
  - After the last beat, s_ack_o rises at k+1.
- Single-lane access to a zero-wait slave: s_ack_o in the cycle after hit+2 clocks, i.e. 2-cycle latency.
- Four lanes, zero-wait: 8 clocks from hit to s_ack_o.
- All outputs are registered; there is no combinational path from s_* to m_* or from m_* to s_*.

## Configuration
- BW_BRIDGE_TIMEOUT_EN defined:
  - A counter clears on each entry to BEAT.
  - If TO_CYCLES clocks pass in BEAT with neither m_ack_i nor m_err_i, the bridge behaves as on m_err_i: err set, DONE, s_err_o.
- Undefined: no counter; the bridge waits indefinitely for the peripheral.

## Structure
- Package bw_bridge_pkg:
  - state typedef (IDLE/BEAT/GAP/DONE)
  - lane-width constants (LANES=4, LANE_W=32)
  - timeout counter width derived from TO_CYCLES
- Sub-module bw_lane_pick: combinational lowest-set-bit encoder.
  - Input pend[3:0]; outputs lane[1:0] and any.

## Test plan
- Read, sel=16'h00F0, adr=32'hFF90_0010, peripheral returns 32'h1234_5678 with zero wait:
  - m_adr_o=32'hFF90_0014, m_sel_o=4'hF.
  - s_dat_o=128'h0000_0000_0000_0000_1234_5678_0000_0000.
  - s_ack_o at hit+2.
- Write, sel=16'hFFFF, s_dat_i=128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA:
  - Four beats at 0x...0, 4, 8, C carrying AAAA_AAAA, BBBB_BBBB, CCCC_CCCC, DDDD_DDDD.
  - m_stb_o low one clock between beats.
  - Single s_ack_o.
- sel=16'h0F0F, m_err_i on first beat:
  - Lane 2 never issued.
  - s_err_o=1, s_ack_o=0, s_dat_o=0.
- Access to 32'h0010_0000 (miss):
  - m_cyc_o never asserts.
  - s_ack_o and s_dat_o stay 0.
- With BW_BRIDGE_TIMEOUT_EN, TO_CYCLES=16, peripheral never acks: s_err_o asserts 16 clocks after m_stb_o rise, ±1 for the sampling edge.
- rst_i pulsed mid-beat of a 4-lane read:
  - m_cyc_o, m_stb_o and s_ack_o go 0 asynchronously.
  - After release, a new single-lane read completes normally.
